// File: rtl/obstacle_spawner.sv
// obstacle_spawner: paces spawn events from the LFSR byte into (lane, kind)
// offers held on a valid/ready handshake until the consumer accepts them.
module obstacle_spawner #(
  parameter int LANES  = 5,
  parameter int PERIOD = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] level,
  input  logic [7:0] random,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [2:0] spawn_lane,
  output logic [1:0] spawn_kind,
  output logic [7:0] spawn_count
);

  localparam int CW = $clog2(PERIOD);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PICK,
    OFFER
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_n;
  logic [2:0]      r_rty;
  logic [2:0]      w_rty_n;
  logic [2:0]      r_last;
  logic [2:0]      w_last_n;
  logic            r_lastv;
  logic            w_lastv_n;
  logic [2:0]      r_lane;
  logic [2:0]      w_lane_n;
  logic [1:0]      r_kind;
  logic [1:0]      w_kind_n;
  logic [7:0]      r_count;
  logic [7:0]      w_count_n;
  logic            r_valid;

  logic [31:0]     w_lim;
  logic            w_done;
  logic [2:0]      w_c;
  logic            w_reject;
  logic [3:0]      w_inc;
  logic [2:0]      w_fb;
  logic            w_unused;

  // Compare with >= so a mid-wait level increase ends the wait at once.
  assign w_lim    = (32'(PERIOD) >> level) - 32'd1;
  assign w_done   = 32'(r_cnt) >= w_lim;

  assign w_c      = random[2:0];
  assign w_reject = ({1'b0, w_c} >= 4'(LANES)) ||
                    (r_lastv && (w_c == r_last));

  assign w_inc    = {1'b0, r_last} + 4'd1;
  assign w_fb     = !r_lastv              ? 3'd0 :
                    (w_inc >= 4'(LANES))  ? 3'd0 :
                                            w_inc[2:0];

  assign w_unused = ^random[5:3];

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_rty_n   = r_rty;
    w_last_n  = r_last;
    w_lastv_n = r_lastv;
    w_lane_n  = r_lane;
    w_kind_n  = r_kind;
    w_count_n = r_count;
    case (r_state)
      IDLE: begin
        w_cnt_n = '0;
        w_rty_n = '0;
        if (enable) w_state_n = WAIT;
      end
      WAIT: begin
        if (!enable) begin
          w_state_n = IDLE;
        end else if (w_done) begin
          w_cnt_n   = '0;
          w_state_n = PICK;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      PICK: begin
        if (!enable) begin
          w_state_n = IDLE;
        end else if (!w_reject) begin
          w_lane_n  = w_c;
          w_kind_n  = random[7:6];
          w_rty_n   = '0;
          w_state_n = OFFER;
        end else if (r_rty != 3'd7) begin
          w_rty_n = r_rty + 3'd1;
        end else begin
          // Eighth straight reject: step past the last lane instead.
          w_lane_n  = w_fb;
          w_kind_n  = random[7:6];
          w_rty_n   = '0;
          w_state_n = OFFER;
        end
      end
      OFFER: begin
        if (spawn_ready) begin
          w_last_n  = r_lane;
          w_lastv_n = 1'b1;
          w_count_n = r_count + 8'd1;
          w_state_n = enable ? WAIT : IDLE;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rty   <= '0;
      r_last  <= '0;
      r_lastv <= 1'b0;
      r_lane  <= '0;
      r_kind  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_rty   <= w_rty_n;
      r_last  <= w_last_n;
      r_lastv <= w_lastv_n;
      r_lane  <= w_lane_n;
      r_kind  <= w_kind_n;
      r_count <= w_count_n;
      r_valid <= (w_state_n == OFFER);
    end
  end

  assign spawn_valid = r_valid;
  assign spawn_lane  = r_lane;
  assign spawn_kind  = r_kind;
  assign spawn_count = r_count;

endmodule

// File: tb/tb_obstacle_spawner.sv
// tb_obstacle_spawner: directed scenarios plus random traffic, checked each
// cycle against a behavioural model of the spawner.
module tb_obstacle_spawner;

  localparam int LANES  = 5;
  localparam int PERIOD = 32;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_PICK  = 2;
  localparam int M_OFFER = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] level = 2'd0;
  logic [7:0] random = 8'd0;
  logic       spawn_ready = 1'b0;
  logic       spawn_valid;
  logic [2:0] spawn_lane;
  logic [1:0] spawn_kind;
  logic [7:0] spawn_count;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  int m_ph = M_IDLE;
  int m_el = 0;
  int m_st = 0;
  int m_lane = 0;
  int m_kind = 0;
  int m_last = 0;
  int m_lastv = 0;
  int m_count = 0;
  int m_c;
  int m_lim;

  obstacle_spawner #(
    .LANES (LANES),
    .PERIOD(PERIOD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .level      (level),
    .random     (random),
    .spawn_ready(spawn_ready),
    .spawn_valid(spawn_valid),
    .spawn_lane (spawn_lane),
    .spawn_kind (spawn_kind),
    .spawn_count(spawn_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: elapsed-wait and reject-streak bookkeeping from the rules.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ph = M_IDLE; m_el = 0; m_st = 0; m_lane = 0; m_kind = 0;
      m_last = 0; m_lastv = 0; m_count = 0;
    end else begin
      m_lim = (PERIOD >> level) - 1;
      m_c   = int'(random) % 8;
      case (m_ph)
        M_IDLE: begin
          m_el = 0; m_st = 0;
          if (enable) m_ph = M_WAIT;
        end
        M_WAIT: begin
          if (!enable) m_ph = M_IDLE;
          else if (m_el >= m_lim) begin m_el = 0; m_ph = M_PICK; end
          else m_el = m_el + 1;
        end
        M_PICK: begin
          if (!enable) m_ph = M_IDLE;
          else if (m_c < LANES && !(m_lastv == 1 && m_c == m_last)) begin
            m_lane = m_c; m_kind = int'(random) / 64; m_st = 0; m_ph = M_OFFER;
          end else if (m_st < 7) m_st = m_st + 1;
          else begin
            m_lane = (m_lastv == 1) ? (m_last + 1) % LANES : 0;
            m_kind = int'(random) / 64; m_st = 0; m_ph = M_OFFER;
          end
        end
        default: begin
          if (spawn_ready) begin
            m_last = m_lane; m_lastv = 1; m_count = (m_count + 1) % 256;
            m_ph = enable ? M_WAIT : M_IDLE;
          end
        end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    chk("valid", int'(spawn_valid), int'(m_ph == M_OFFER));
    chk("lane", int'(spawn_lane), m_lane);
    chk("kind", int'(spawn_kind), m_kind);
    chk("count", int'(spawn_count), m_count);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (spawn_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk(nm, int'(got), 1);
  endtask

  initial begin
    int last_v;
    bit seen;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", int'(spawn_valid), 0);
    chk("rst_lane", int'(spawn_lane), 0);
    chk("rst_kind", int'(spawn_kind), 0);
    chk("rst_count", int'(spawn_count), 0);

    // Basic event: valid after edge 34 for one cycle.
    random = 8'hC2; spawn_ready = 1'b1; level = 2'd0; enable = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      tick();
      if (e == 33) chk("basic_early", int'(spawn_valid), 0);
      if (e == 34) begin
        chk("basic_valid", int'(spawn_valid), 1);
        chk("basic_lane", int'(spawn_lane), 2);
        chk("basic_kind", int'(spawn_kind), 3);
        chk("model_lane", m_lane, 2);
      end
      if (e == 35) begin
        chk("basic_pulse", int'(spawn_valid), 0);
        chk("basic_count", int'(spawn_count), 1);
      end
    end
    enable = 1'b0;
    tick();
    tick();

    // Rejection: eight rejects then fallback lane 0.
    do_reset();
    random = 8'h07; spawn_ready = 1'b0; enable = 1'b1;
    for (int e = 1; e <= 41; e++) begin
      tick();
      if (e == 40) chk("rej_early", int'(spawn_valid), 0);
      if (e == 41) begin
        chk("rej_valid", int'(spawn_valid), 1);
        chk("rej_lane", int'(spawn_lane), 0);
        chk("rej_kind", int'(spawn_kind), 0);
      end
    end
    random = 8'h04; spawn_ready = 1'b1;
    tick();
    spawn_ready = 1'b0;
    wait_valid(100, "lane4_wait");
    chk("lane4", int'(spawn_lane), 4);
    random = 8'h07; spawn_ready = 1'b1;
    tick();
    spawn_ready = 1'b0;
    wait_valid(100, "wrap_wait");
    chk("wrap_lane", int'(spawn_lane), 0);

    // No repeat: lane 2 accepted, then 02 rejected once, 43 gives lane 3.
    level = 2'd3; random = 8'hC2; spawn_ready = 1'b1;
    tick();
    wait_valid(40, "nr_wait");
    chk("nr_lane2", int'(spawn_lane), 2);
    random = 8'h02;
    repeat (6) tick();
    chk("nr_reject", int'(spawn_valid), 0);
    random = 8'h43;
    tick();
    chk("nr_valid", int'(spawn_valid), 1);
    chk("nr_lane", int'(spawn_lane), 3);
    chk("nr_kind", int'(spawn_kind), 1);
    spawn_ready = 1'b0;

    // Backpressure with changing random and enable dropping.
    for (int i = 0; i < 5; i++) begin
      random = 8'($urandom);
      if (i == 2) enable = 1'b0;
      tick();
      chk("bp_valid", int'(spawn_valid), 1);
      chk("bp_lane", int'(spawn_lane), 3);
      chk("bp_kind", int'(spawn_kind), 1);
    end
    chk("bp_count_pre", int'(spawn_count), 4);
    spawn_ready = 1'b1;
    tick();
    chk("bp_count", int'(spawn_count), 5);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (spawn_valid) seen = 1'b1;
    end
    chk("bp_idle", int'(seen), 0);

    // Reset mid-offer discards it and clears the repeat history.
    spawn_ready = 1'b0; random = 8'hC2; enable = 1'b1;
    wait_valid(40, "ro_wait");
    rst_n = 1'b0;
    tick();
    chk("ro_valid", int'(spawn_valid), 0);
    chk("ro_lane", int'(spawn_lane), 0);
    chk("ro_kind", int'(spawn_kind), 0);
    chk("ro_count", int'(spawn_count), 0);
    rst_n = 1'b1; random = 8'h03;
    wait_valid(40, "ro_wait2");
    chk("ro_lane3", int'(spawn_lane), 3);
    spawn_ready = 1'b1;
    tick();
    chk("ro_count1", int'(spawn_count), 1);
    enable = 1'b0;
    tick();
    tick();

    // Level 3 cadence and counter wrap.
    do_reset();
    level = 2'd3; spawn_ready = 1'b1; random = 8'h01; enable = 1'b1;
    last_v = 0;
    for (int k = 0; k < 256; k++) begin
      wait_valid(20, "lv_wait");
      chk("lv_lane", int'(spawn_lane), (k % 2 == 1) ? 2 : 1);
      if (k > 0) chk("lv_interval", cyc - last_v, 6);
      if (k == 255) chk("lv_count255", int'(spawn_count), 255);
      last_v = cyc;
      random = (random == 8'h01) ? 8'h02 : 8'h01;
    end
    tick();
    chk("lv_wrap", int'(spawn_count), 0);
    enable = 1'b0;
    tick();

    // Random traffic against the model.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      random = 8'($urandom);
      spawn_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) level = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
